// File: rtl/game_round_ctrl.sv
// Round sequencer for the reaction game: key edge detection, game FSM,
// per-round countdown, timeout tally and accumulated play seconds.
module game_round_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int TIME_LIMIT = 10,
  parameter int ROUNDS     = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_next,
  input  logic        i_finish_key,
  output logic [2:0]  o_state,
  output logic [3:0]  o_timeout,
  output logic [3:0]  o_timecount,
  output logic [17:0] o_sec,
  output logic [3:0]  o_round,
  output logic        o_round_start,
  output logic        o_game_over
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_next_q;
  logic            r_fin_q;
  logic [PW-1:0]   r_presc;
  logic [3:0]      r_timecount;
  logic [3:0]      r_timeout;
  logic [17:0]     r_sec;
  logic [3:0]      r_round;
  logic            r_round_start;

  logic w_next_rise;
  logic w_fin_rise;
  logic w_tick;
  logic w_clr_game;
  logic w_start_round;
  logic w_dec;
  logic w_expire;
  logic w_round_inc;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [17:0] sat_inc18(input logic [17:0] v);
    return (v == 18'h3FFFF) ? v : v + 18'd1;
  endfunction

  assign w_next_rise = i_next & ~r_next_q;
  assign w_fin_rise  = i_finish_key & ~r_fin_q;
  assign w_tick      = (r_state == S_PLAY) && (r_presc == PRESC_MAX);

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_game    = 1'b0;
    w_start_round = 1'b0;
    w_dec         = 1'b0;
    w_expire      = 1'b0;
    w_round_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_next_rise) begin
          w_state_nxt = S_READY;
          w_clr_game  = 1'b1;
        end
      end
      S_READY: begin
        if (w_next_rise) begin
          w_state_nxt   = S_PLAY;
          w_start_round = 1'b1;
        end
      end
      S_PLAY: begin
        // A finish press beats an expiring tick in the same cycle.
        if (w_fin_rise) begin
          w_state_nxt = S_WIN;
        end else if (w_tick) begin
          if (r_timecount <= 4'd1) begin
            w_state_nxt = S_LOSE;
            w_expire    = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (w_next_rise) begin
          w_round_inc = 1'b1;
          w_state_nxt = ((r_round + 4'd1) == 4'(ROUNDS)) ? S_DONE : S_READY;
        end
      end
      S_DONE: begin
        if (w_next_rise) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // Key history starts high so a key held through reset yields no edge.
      r_next_q      <= 1'b1;
      r_fin_q       <= 1'b1;
      r_presc       <= '0;
      r_timecount   <= 4'd0;
      r_timeout     <= 4'd0;
      r_sec         <= 18'd0;
      r_round       <= 4'd0;
      r_round_start <= 1'b0;
    end else begin
      r_next_q      <= i_next;
      r_fin_q       <= i_finish_key;
      r_round_start <= w_start_round;

      if (w_start_round)           r_presc <= '0;
      else if (r_state == S_PLAY)  r_presc <= w_tick ? '0 : r_presc + 1'b1;

      if (w_clr_game) begin
        r_timeout <= 4'd0;
        r_sec     <= 18'd0;
        r_round   <= 4'd0;
      end

      if (w_start_round) begin
        r_timecount <= 4'(TIME_LIMIT);
      end else if (w_dec) begin
        r_timecount <= r_timecount - 4'd1;
        r_sec       <= sat_inc18(r_sec);
      end else if (w_expire) begin
        r_timecount <= 4'd0;
        r_sec       <= sat_inc18(r_sec);
        r_timeout   <= sat_inc4(r_timeout);
      end

      if (w_round_inc) r_round <= r_round + 4'd1;
    end
  end

  assign o_state       = r_state;
  assign o_timeout     = r_timeout;
  assign o_timecount   = r_timecount;
  assign o_sec         = r_sec;
  assign o_round       = r_round;
  assign o_round_start = r_round_start;
  assign o_game_over   = (r_state == S_DONE);

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with TICK_DIV=4, TIME_LIMIT=3, ROUNDS=2.
module tb_game_round_ctrl;

  logic        clk;
  logic        rst;
  logic        nxt;
  logic        fin;
  logic [2:0]  state;
  logic [3:0]  timeout;
  logic [3:0]  timecount;
  logic [17:0] sec;
  logic [3:0]  round;
  logic        round_start;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  game_round_ctrl #(.TICK_DIV(4), .TIME_LIMIT(3), .ROUNDS(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_next       (nxt),
    .i_finish_key (fin),
    .o_state      (state),
    .o_timeout    (timeout),
    .o_timecount  (timecount),
    .o_sec        (sec),
    .o_round      (round),
    .o_round_start(round_start),
    .o_game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Rising edge on next lands on the following clock edge; key dropped afterwards.
  task automatic pulse_next();
    nxt = 1'b1;
    step(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_timecount"}, 32'(timecount), 0);
    chk({tag, "_sec"}, 32'(sec), 0);
    chk({tag, "_round"}, 32'(round), 0);
    chk({tag, "_rstart"}, 32'(round_start), 0);
    chk({tag, "_gover"}, 32'(game_over), 0);
  endtask

  initial begin
    rst = 1'b1;
    nxt = 1'b1;
    fin = 1'b0;
    #2;
    chk_all_zero("reset");
    step(2);
    rst = 1'b0;
    step(2);
    chk("held_next_no_edge", 32'(state), 0);
    nxt = 1'b0;
    step(1);
    pulse_next();
    chk("idle_to_ready", 32'(state), 1);
    nxt = 1'b0;
    step(1);

    // Round 1: enter PLAY, first tick 4 clocks later, finish at clock 6.
    pulse_next();
    chk("play_entry", 32'(state), 2);
    chk("rstart_hi", 32'(round_start), 1);
    chk("tc_load", 32'(timecount), 3);
    nxt = 1'b0;
    step(1);
    chk("rstart_lo", 32'(round_start), 0);
    step(2);
    chk("tc_before_tick", 32'(timecount), 3);
    step(1);
    chk("tc_tick1", 32'(timecount), 2);
    chk("sec_tick1", 32'(sec), 1);
    step(1);
    fin = 1'b1;
    step(1);
    chk("win_state", 32'(state), 3);
    chk("win_tc", 32'(timecount), 2);
    fin = 1'b0;
    step(4);
    chk("win_tc_frozen", 32'(timecount), 2);
    chk("win_sec_frozen", 32'(sec), 1);
    pulse_next();
    chk("win_to_ready", 32'(state), 1);
    chk("round1", 32'(round), 1);
    nxt = 1'b0;
    step(1);
    fin = 1'b1;
    step(1);
    chk("fin_ignored_ready", 32'(state), 1);
    fin = 1'b0;
    step(1);

    // Round 2: run to timeout; next press in PLAY is ignored.
    pulse_next();
    chk("play2_entry", 32'(state), 2);
    nxt = 1'b0;
    step(1);
    nxt = 1'b1;
    step(1);
    chk("next_ignored_play", 32'(state), 2);
    nxt = 1'b0;
    step(2);
    chk("r2_tc_tick1", 32'(timecount), 2);
    step(4);
    chk("r2_tc_tick2", 32'(timecount), 1);
    chk("r2_state_tick2", 32'(state), 2);
    step(4);
    chk("lose_tc", 32'(timecount), 0);
    chk("lose_state", 32'(state), 4);
    chk("lose_timeout", 32'(timeout), 1);
    chk("lose_sec", 32'(sec), 4);
    step(5);
    chk("lose_sec_held", 32'(sec), 4);
    chk("lose_tc_held", 32'(timecount), 0);
    pulse_next();
    chk("done_state", 32'(state), 5);
    chk("done_gover", 32'(game_over), 1);
    chk("done_round", 32'(round), 2);
    nxt = 1'b0;
    step(1);
    pulse_next();
    chk("done_to_idle", 32'(state), 0);
    chk("idle_gover", 32'(game_over), 0);
    chk("idle_keep_timeout", 32'(timeout), 1);
    chk("idle_keep_sec", 32'(sec), 4);
    chk("idle_keep_round", 32'(round), 2);
    nxt = 1'b0;
    step(1);
    pulse_next();
    chk("new_game_ready", 32'(state), 1);
    chk("clr_timeout", 32'(timeout), 0);
    chk("clr_sec", 32'(sec), 0);
    chk("clr_round", 32'(round), 0);
    nxt = 1'b0;
    step(1);

    // Finish coincides with the expiring tick: finish wins.
    pulse_next();
    nxt = 1'b0;
    step(10);
    chk("tie_pre_tc", 32'(timecount), 1);
    step(1);
    fin = 1'b1;
    step(1);
    chk("tie_state", 32'(state), 3);
    chk("tie_tc", 32'(timecount), 1);
    chk("tie_timeout", 32'(timeout), 0);
    chk("tie_sec", 32'(sec), 2);
    fin = 1'b0;
    step(1);
    pulse_next();
    chk("tie_to_ready", 32'(state), 1);
    chk("tie_round", 32'(round), 1);
    nxt = 1'b0;
    step(1);

    // Asynchronous reset in the middle of PLAY.
    pulse_next();
    nxt = 1'b0;
    step(5);
    chk("pre_rst_state", 32'(state), 2);
    chk("pre_rst_tc", 32'(timecount), 2);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    step(2);
    rst = 1'b0;
    step(1);
    chk("post_rst_state", 32'(state), 0);
    chk("post_rst_rstart", 32'(round_start), 0);
    step(6);
    chk("post_rst_idle", 32'(state), 0);
    chk("post_rst_tc", 32'(timecount), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
